aud_dac_tx: RTL

I2S transmitter for the WM8731 DAC path: buffers merged 16-bit mono samples in a small FIFO and serialises each one, MSB first, onto o_AUD_DACDAT for both the left and right slots of every LRCK frame. Sits downstream of the sample-merge stage and consumes its output through a valid/ready handshake. BCLK and DACLRCK come from the codec and are oversampled in the system clock domain.

---
 rtl/aud_dac_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/aud_dac_tx.sv
// I2S DAC transmitter: buffers mono samples in a FIFO and sends each one in both LRCK slots, MSB first.
// Optional `AUD_DAC_TX_UNDERFLOW_HOLD_EN: an underflow repeats the last sample instead of sending silence.
module aud_dac_tx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_AUD_BCLK,
    input  logic                          i_AUD_DACLRCK,
    input  logic                          i_en,
    input  logic                          i_valid,
    input  logic [DATA_W-1:0]             i_data,
    output logic                          o_ready,
    output logic                          o_AUD_DACDAT,
    output logic                          o_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, ARM, SHIFT, PAD} state_t;

    state_t              state, state_nxt;
    logic [2:0]          bclk_sr, lrck_sr;
    logic                bclk_fall, lrck_fall, lrck_rise;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                rdy_en;
    logic                push, pop, fifo_empty, underflow;
    logic                load_left, load_right;
    logic [DATA_W-1:0]   sr, sr_nxt, held, held_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                dat_nxt;

    // Two synchroniser flops, then a third flop as the edge-detect reference
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_sr <= '0;
            lrck_sr <= '0;
        end else begin
            bclk_sr <= {bclk_sr[1:0], i_AUD_BCLK};
            lrck_sr <= {lrck_sr[1:0], i_AUD_DACLRCK};
        end
    end

    assign bclk_fall = bclk_sr[2] & ~bclk_sr[1];
    assign lrck_fall = lrck_sr[2] & ~lrck_sr[1];
    assign lrck_rise = ~lrck_sr[2] & lrck_sr[1];

    // FIFO
    assign fifo_empty  = (o_level == '0);
    assign o_ready     = rdy_en & (o_level < LW'(FIFO_DEPTH));
    assign push        = i_valid & o_ready;
    assign pop         = load_left & ~fifo_empty;
    assign underflow   = load_left & fifo_empty;
    assign o_underflow = underflow;

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
            rdy_en  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   o_level <= o_level + LW'(1);
                2'b01:   o_level <= o_level - LW'(1);
                default: o_level <= o_level;
            endcase
        end
    end

    // Serialiser FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            sr           <= '0;
            held         <= '0;
            cnt          <= '0;
            o_AUD_DACDAT <= 1'b0;
        end else begin
            state        <= state_nxt;
            sr           <= sr_nxt;
            held         <= held_nxt;
            cnt          <= cnt_nxt;
            o_AUD_DACDAT <= dat_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        held_nxt   = held;
        cnt_nxt    = cnt;
        dat_nxt    = o_AUD_DACDAT;
        load_left  = 1'b0;
        load_right = 1'b0;

        case (state)
            IDLE: begin
                dat_nxt = 1'b0;
                if (lrck_fall && i_en) begin
                    load_left = 1'b1;
                    state_nxt = ARM;
                end
            end
            default: begin
                // Slot edges take priority over bit timing; an edge in SHIFT drops the remaining bits
                if (lrck_fall && !i_en) begin
                    state_nxt = IDLE;
                    dat_nxt   = 1'b0;
                end else if (lrck_fall) begin
                    load_left = 1'b1;
                    state_nxt = ARM;
                    dat_nxt   = 1'b0;
                end else if (lrck_rise) begin
                    load_right = 1'b1;
                    state_nxt  = ARM;
                    dat_nxt    = 1'b0;
                end else if (bclk_fall) begin
                    case (state)
                        ARM: begin
                            dat_nxt   = sr[DATA_W-1];
                            sr_nxt    = sr << 1;
                            cnt_nxt   = CW'(DATA_W - 2);
                            state_nxt = SHIFT;
                        end
                        SHIFT: begin
                            // cnt wraps past zero after bit 0, its MSB then marks the slot as done
                            if (cnt[CW-1]) begin
                                dat_nxt   = 1'b0;
                                state_nxt = PAD;
                            end else begin
                                dat_nxt = sr[DATA_W-1];
                                sr_nxt  = sr << 1;
                                cnt_nxt = cnt - CW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        if (load_left) begin
            if (fifo_empty) begin
`ifdef AUD_DAC_TX_UNDERFLOW_HOLD_EN
                held_nxt = held;
`else
                held_nxt = '0;
`endif
            end else begin
                held_nxt = mem[rd_ptr];
            end
            sr_nxt = held_nxt;
        end
        if (load_right) sr_nxt = held;
    end

endmodule
